// File: rtl/dis_sqrt_unit.sv
`default_nettype none
// ============================================================================
// Module   : dis_sqrt_unit
// Purpose  : Iterative integer square root of the signed sphere-intersection
//            discriminant. Produces floor(sqrt(dis)) one radicand bit-pair
//            per cycle, plus a hit flag (dis >= 0) and a pass-through tag.
//            One operation in flight; valid/ready handshake on both sides.
// Ports    : clk        - clock, rising edge
//            rstn       - asynchronous active-low reset
//            in_valid   - in_dis / in_tag valid
//            in_ready   - unit idle and able to accept
//            in_dis     - signed discriminant (DIS_W bits)
//            in_tag     - opaque sideband (TAG_W bits)
//            out_valid  - result valid
//            out_ready  - downstream accepts result
//            out_root   - floor(sqrt(in_dis)), 0 when negative
//            out_hit    - 1 when in_dis >= 0
//            out_tag    - copy of in_tag latched on accept
// Revision : 1.0 - initial release
// ============================================================================
module dis_sqrt_unit #(
    parameter int DIS_W  = 51,
    parameter int ROOT_W = 27,
    parameter int TAG_W  = 20
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIS_W-1:0]  in_dis,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROOT_W-1:0] out_root,
    output logic              out_hit,
    output logic [TAG_W-1:0]  out_tag
);

    // Radicand is the sign-cleared discriminant padded up to an even width so
    // it splits cleanly into bit-pairs, MSB pair first.
    localparam int C_RAD_W = ((DIS_W + 1) % 2 == 0) ? (DIS_W + 1) : (DIS_W + 2);
    localparam int C_PAIRS = C_RAD_W / 2;
    localparam int C_RT_W  = C_PAIRS;
    // Remainder never exceeds 2*root, so root width + 2 holds rem<<2 | pair.
    localparam int C_REM_W = C_PAIRS + 2;
    localparam int C_CNT_W = $clog2(C_PAIRS);
    localparam int C_PAD   = C_RAD_W - DIS_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [C_RAD_W-1:0]   rad_q,   rad_d;
    logic [C_REM_W-1:0]   rem_q,   rem_d;
    logic [C_RT_W-1:0]    root_q,  root_d;
    logic [C_CNT_W-1:0]   cnt_q,   cnt_d;
    logic                 hit_q,   hit_d;
    logic [TAG_W-1:0]     tag_q,   tag_d;

    logic [C_REM_W-1:0]   rem_shift;
    logic [C_REM_W-1:0]   trial;

    // Bring down the next radicand bit-pair; trial divisor is 4*root + 1.
    assign rem_shift = {rem_q[C_REM_W-3:0], rad_q[C_RAD_W-1 -: 2]};
    assign trial     = {root_q, 2'b01};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        tag_d   = tag_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    tag_d = in_tag;
                    if (in_dis[DIS_W-1]) begin
                        // Negative discriminant: miss, no iteration needed.
                        root_d  = '0;
                        hit_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        rad_d   = C_RAD_W'({1'b0, in_dis}) << C_PAD;
                        rem_d   = '0;
                        root_d  = '0;
                        hit_d   = 1'b0;
                        cnt_d   = C_CNT_W'(C_PAIRS - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (rem_shift >= trial) begin
                    rem_d  = rem_shift - trial;
                    root_d = {root_q[C_RT_W-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift;
                    root_d = {root_q[C_RT_W-2:0], 1'b0};
                end
                rad_d = rad_q << 2;
                if (cnt_q == '0) begin
                    hit_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_root  = ROOT_W'(root_q);
    assign out_hit   = hit_q;
    assign out_tag   = tag_q;

endmodule
`default_nettype wire

// File: doc/dis_sqrt_unit.md
# dis_sqrt_unit

Iterative integer square-root stage for the sphere-intersection datapath.
- Consumes the signed discriminant (`DIS_B` = 51 bits) from the discriminant stage.
- Produces `floor(sqrt(dis))` at `DIS_SQRT_B` = 27 bits, plus a hit flag, for the distance stage.
- A pass-through tag carries the pixel/sphere identity alongside each result.
- One operation is in flight at a time, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `DIS_W`, default 51 (`DIS_B`): discriminant width, signed two's complement.
- `ROOT_W`, default 27 (`DIS_SQRT_B`): root output width.
- `TAG_W`, default 20: opaque sideband carried from input to output.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  discriminant on `in_dis`/`in_tag` is valid.
- `in_ready`  out  1  unit can accept; equals (state == IDLE).
- `in_dis`  in  `DIS_W`  signed discriminant.
- `in_tag`  in  `TAG_W`  sideband.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_root`  out  `ROOT_W`  `floor(sqrt(in_dis))`, zero-extended; 0 when the discriminant is negative.
- `out_hit`  out  1  1 if `in_dis` ≥ 0 (ray meets sphere), else 0.
- `out_tag`  out  `TAG_W`  registered copy of `in_tag`.

## Operation
States: IDLE, CALC, DONE.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `in_tag`.
  - If `in_dis[DIS_W-1]`=1 (negative): set root=0, hit=0, go to DONE.
  - Otherwise:
    - Load radicand = {1'b0, `in_dis`}, zero-padded to 52 bits (even).
    - Clear the remainder and root registers.
    - Set the pair counter to 25 and go to CALC.
- **CALC** (digit-by-digit, one radicand bit-pair per cycle)
  - rem' = (rem << 2) | next two radicand MSBs.
  - trial = (root << 2) | 1.
  - If rem' ≥ trial: rem = rem' − trial, root = (root << 1) | 1.
  - Else: rem = rem', root = root << 1.
  - Shift the radicand left by 2.
  - When counter = 0, go to DONE with hit=1; else decrement the counter.
  - Remainder register width: 28 bits. Root register: 26 bits, zero-extended to `ROOT_W`.
- **DONE**
  - `out_valid`=1; `out_root`, `out_hit`, `out_tag` held stable.
  - On `out_ready`: go to IDLE.
- Rounding is floor; no fractional bits are produced. Fixed-point rescaling is the consumer's job.
- `in_ready` is 0 in CALC and DONE. Input changes there are ignored.
- `in_dis` = 0 takes the normal CALC path and yields root=0, hit=1.

## Timing
- Reset (`rstn` low, asynchronous):
  - state=IDLE, `out_valid`=0, `out_root`=0, `out_hit`=0, `out_tag`=0, counter=0.
  - `in_ready`=1 immediately (combinational from state).
- Reset mid-CALC or mid-DONE: the operation is abandoned with no output. The unit is in IDLE on the first edge after `rstn` deasserts.
- Non-negative input accepted at edge E0: CALC occupies edges E1..E26, `out_valid` rises after E26. Latency is 26 cycles from accept to `out_valid`.
- Negative input accepted at E0: `out_valid` rises after E0. Latency is 1 cycle.
- Result handshake completes at the edge where `out_valid` && `out_ready`. `out_valid` drops after that edge and `in_ready` rises in the same cycle.
- No accept in the same cycle as a result handshake.
- Minimum issue interval:
  - Non-negative: 28 cycles (accept, 26 CALC, 1 DONE with `out_ready`=1).
  - Negative: 2 cycles.
- Backpressure: DONE holds indefinitely with all outputs stable while `out_ready`=0.
- `out_ready` asserted outside DONE has no effect.

## Test plan
- Exact squares, `in_dis` = 0, 1, 4, 1000000 → `out_root` = 0, 1, 2, 1000. `out_hit`=1 each time, `out_valid` exactly 26 cycles after accept.
- Floor and extremes:
  - 999999 → 999.
  - 2 → 1.
  - Maximum positive 2^50−1 → 33554431 (2^25−1), no overflow of the remainder.
- Negative inputs −1 and −2^50 → `out_root`=0, `out_hit`=0, `out_valid` 1 cycle after accept, `in_ready`=0 while `out_valid`=1.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → outputs and `out_tag` unchanged, `in_ready`=0. Then pulse `out_ready` → `out_valid`=0 and `in_ready`=1 next cycle.
- Reset mid-operation: assert `rstn`=0 at CALC cycle 12 → `out_valid`=0 and `in_ready`=1 asynchronously. A new input of 81 after release → 9 with correct tag.
- 10000 random signed 51-bit inputs with random `in_valid`/`out_ready` gaps → every result matches a floor-sqrt reference model with tag order preserved, and no result is dropped or duplicated.
